div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have no parameters; data width fixed at 32.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  EXE holds a valid div/mod instruction
- req_op  in  2  operation: 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- src1  in  32  dividend
- src2  in  32  divisor
- res_ack  in  1  EXE consumes the result (es_ready_go & ms_allowin)
- flush  in  1  cancel the current instruction
- s_dividend_tvalid  out  2  dividend tvalid; [0] signed IP, [1] unsigned IP
- s_divisor_tvalid  out  2  divisor tvalid; same bit mapping
- s_dividend_tready  in  2  dividend tready from each IP
- s_divisor_tready  in  2  divisor tready from each IP
- s_dividend_tdata  out  32  latched dividend, shared by both IPs
- s_divisor_tdata  out  32  latched divisor, shared by both IPs
- m_dout_tvalid  in  2  result valid from each IP
- m_dout_tdata_s  in  64  signed IP result {quotient, remainder}
- m_dout_tdata_u  in  64  unsigned IP result {quotient, remainder}
- busy  out  1  an operation is in flight (any state except IDLE)
- done  out  1  result valid in the result register
- result  out  32  selected quotient or remainder

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-004 In IDLE with req_valid=1 and flush=0, SHALL latch src1, src2 and req_op, and go to ISSUE next cycle.
REQ-005 In ISSUE, SHALL drive tvalid only on the IP selected by req_op[1] (0 = signed, 1 = unsigned); the other IP's tvalid stays 0.
REQ-006 SHALL track dividend and divisor handshakes independently with got_dnd/got_dvs flags; a channel's tvalid drops the cycle after its tvalid&tready.
REQ-007 Once a channel's tvalid is asserted, it SHALL stay asserted until that channel's handshake completes (AXI-Stream rule), even across flush.
REQ-008 Moving on from ISSUE:
- both flags set, flush never seen: go to WAIT
- both flags set, flush seen during ISSUE: go to DRAIN
- handshakes on both channels in the same cycle: leave ISSUE next cycle
REQ-009 In WAIT, m_dout_tvalid of the selected IP SHALL load result and go to DONE.
- result = quotient [63:32] for div ops, remainder [31:0] for mod ops
REQ-010 In DONE, done=1; res_ack SHALL return to IDLE; result stays stable until then.
REQ-011 A req_valid in the cycle DONE exits SHALL NOT start a new operation; a new operation starts only from IDLE, so there is at least one idle cycle between operations.
REQ-012 flush handling:
- in WAIT: go to DRAIN
- in DONE: go to IDLE, done drops next cycle
- in IDLE: ignore any req_valid that cycle
REQ-013 In DRAIN, the selected IP's m_dout_tvalid SHALL be consumed and discarded, then go to IDLE; done stays 0.
REQ-014 m_dout_tvalid from the non-selected IP, or in IDLE or DONE, SHALL be ignored.
REQ-015 Divide-by-zero SHALL pass through the IP result unmodified; no exception flag.
REQ-016 busy=1 in ISSUE, WAIT, DONE and DRAIN.

Reset
REQ-017 reset SHALL force: state IDLE, all tvalid outputs 0, got flags 0, done=0, busy=0, result=0.
REQ-018 reset SHALL take priority over all inputs, including mid-handshake or mid-WAIT; a result arriving later is not forwarded.

Verification
REQ-019 Signed div/mod: req_op=00, src1=0xFFFFFFF9 (-7), src2=2, both treadys high, IP returns {0xFFFFFFFD, 0xFFFFFFFF}.
- Required: tvalid[0] high exactly 1 cycle, then result=0xFFFFFFFD with done=1.
- Repeat with req_op=01: result=0xFFFFFFFF.
REQ-020 Unsigned: req_op=11, src1=0xFFFFFFFF, src2=16, IP returns {0x0FFFFFFF, 0x0000000F}.
- Required: result=0x0000000F; unsigned tvalid only, s_*_tvalid[0] stays 0 throughout.
REQ-021 Staggered tready: dividend tready at cycle 1, divisor tready at cycle 4.
- Required: dividend tvalid drops after cycle 1; divisor tvalid stays high through cycle 4; WAIT entered once.
REQ-022 Flush in ISSUE with divisor tready low for 3 cycles.
- Required: divisor tvalid held until handshake; DRAIN entered; the later dout_tvalid is discarded; done never asserts; IDLE afterwards.
REQ-023 Flush in DONE, and flush in WAIT.
- Required (DONE): done=0 next cycle.
- Required (WAIT): DRAIN entered, result register unchanged, next request completes normally.
REQ-024 Reset asserted in WAIT.
- Required: next cycle all outputs at reset values; a dout_tvalid arriving afterwards leaves done=0.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue and collect control for a pair of divider IPs.
// Latches one div/mod request, handshakes both operands, then waits for the result.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        res_ack,
    input  logic        flush,
    output logic [1:0]  s_dividend_tvalid,
    output logic [1:0]  s_divisor_tvalid,
    input  logic [1:0]  s_dividend_tready,
    input  logic [1:0]  s_divisor_tready,
    output logic [31:0] s_dividend_tdata,
    output logic [31:0] s_divisor_tdata,
    input  logic [1:0]  m_dout_tvalid,
    input  logic [63:0] m_dout_tdata_s,
    input  logic [63:0] m_dout_tdata_u,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  op_q;
    logic [31:0] dnd_q;
    logic [31:0] dvs_q;
    logic [31:0] res_q;
    logic        got_dnd;
    logic        got_dvs;
    logic        flush_seen;
    logic        dnd_tv;
    logic        dvs_tv;
    logic        dnd_rdy;
    logic        dvs_rdy;
    logic        dnd_hs;
    logic        dvs_hs;
    logic        both_got;
    logic        out_valid;
    logic [63:0] out_data;
    logic        accept;
    logic        load;

    // op_q[1] picks the IP: 0 = signed, 1 = unsigned
    assign dnd_rdy   = op_q[1] ? s_dividend_tready[1] : s_dividend_tready[0];
    assign dvs_rdy   = op_q[1] ? s_divisor_tready[1]  : s_divisor_tready[0];
    assign out_valid = op_q[1] ? m_dout_tvalid[1]     : m_dout_tvalid[0];
    assign out_data  = op_q[1] ? m_dout_tdata_u       : m_dout_tdata_s;

    assign dnd_hs   = dnd_tv & dnd_rdy;
    assign dvs_hs   = dvs_tv & dvs_rdy;
    assign both_got = (got_dnd | dnd_hs) & (got_dvs | dvs_hs);
    assign accept   = (state == IDLE) & req_valid & ~flush;
    assign load     = (state == WAIT) & out_valid & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (both_got)
                    state_nxt = (flush_seen | flush) ? DRAIN : WAIT;
            end
            WAIT: begin
                // a result landing with the flush is simply dropped
                if (flush)
                    state_nxt = out_valid ? IDLE : DRAIN;
                else if (out_valid)
                    state_nxt = DONE;
            end
            DONE: begin
                if (res_ack | flush) state_nxt = IDLE;
            end
            DRAIN: begin
                if (out_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dnd_tv            = (state == ISSUE) & ~got_dnd;
        dvs_tv            = (state == ISSUE) & ~got_dvs;
        s_dividend_tvalid = op_q[1] ? {dnd_tv, 1'b0} : {1'b0, dnd_tv};
        s_divisor_tvalid  = op_q[1] ? {dvs_tv, 1'b0} : {1'b0, dvs_tv};
        busy              = (state != IDLE);
        done              = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 2'b00;
            dnd_q      <= 32'h0;
            dvs_q      <= 32'h0;
            got_dnd    <= 1'b0;
            got_dvs    <= 1'b0;
            flush_seen <= 1'b0;
            res_q      <= 32'h0;
        end else begin
            if (accept) begin
                op_q       <= req_op;
                dnd_q      <= src1;
                dvs_q      <= src2;
                got_dnd    <= 1'b0;
                got_dvs    <= 1'b0;
                flush_seen <= 1'b0;
            end else if (state == ISSUE) begin
                got_dnd    <= got_dnd | dnd_hs;
                got_dvs    <= got_dvs | dvs_hs;
                flush_seen <= flush_seen | flush;
            end
            if (load)
                res_q <= op_q[0] ? out_data[31:0] : out_data[63:32];
        end
    end

    assign s_dividend_tdata = dnd_q;
    assign s_divisor_tdata  = dvs_q;
    assign result           = res_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: scoreboard bench with divider IP models for div_issue_ctrl.
// Directed cases first, then randomized operations, flushes and resets.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        res_ack;
    logic        flush;
    logic [1:0]  s_dividend_tvalid;
    logic [1:0]  s_divisor_tvalid;
    logic [1:0]  s_dividend_tready = 2'b00;
    logic [1:0]  s_divisor_tready = 2'b00;
    logic [31:0] s_dividend_tdata;
    logic [31:0] s_divisor_tdata;
    logic [1:0]  m_dout_tvalid = 2'b00;
    logic [63:0] m_dout_tdata_s = 64'h0;
    logic [63:0] m_dout_tdata_u = 64'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_op            (req_op),
        .src1              (src1),
        .src2              (src2),
        .res_ack           (res_ack),
        .flush             (flush),
        .s_dividend_tvalid (s_dividend_tvalid),
        .s_divisor_tvalid  (s_divisor_tvalid),
        .s_dividend_tready (s_dividend_tready),
        .s_divisor_tready  (s_divisor_tready),
        .s_dividend_tdata  (s_dividend_tdata),
        .s_divisor_tdata   (s_divisor_tdata),
        .m_dout_tvalid     (m_dout_tvalid),
        .m_dout_tdata_s    (m_dout_tdata_s),
        .m_dout_tdata_u    (m_dout_tdata_u),
        .busy              (busy),
        .done              (done),
        .result            (result)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  cur_op = 2'b00;
    int          ip_lat = 1;
    bit          script_en = 1'b0;
    int          dnd_at = 1;
    int          dvs_at = 1;
    bit          noise_en = 1'b0;
    int          dnd_cnt = 0;
    int          dvs_cnt = 0;
    logic [31:0] last_exp = 32'h0;

    // Divider IP behaviour: {quotient, remainder}; x/0 gives all-ones and x
    function automatic logic [63:0] div_ref(input bit sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'h0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] expect_of(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] d;
        d = div_ref(!op[1], a, b);
        return op[0] ? d[31:0] : d[63:32];
    endfunction

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_t c;
        c.name = n;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // IP models: operand capture, latency countdown, ready generation
    logic [1:0]  p_tv_a = 2'b00;
    logic [1:0]  p_tv_b = 2'b00;
    logic [1:0]  p_rd_a = 2'b00;
    logic [1:0]  p_rd_b = 2'b00;
    logic [31:0] cap_a[2];
    logic [31:0] cap_b[2];
    bit          g_a[2];
    bit          g_b[2];
    bit          pend[2];
    int          cnt[2];
    int          issue_cyc = 0;

    always @(posedge clk) begin
        logic [63:0] d;
        #1;
        m_dout_tvalid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (p_tv_a[i] && p_rd_a[i]) begin
                cap_a[i] = s_dividend_tdata;
                g_a[i] = 1'b1;
            end
            if (p_tv_b[i] && p_rd_b[i]) begin
                cap_b[i] = s_divisor_tdata;
                g_b[i] = 1'b1;
            end
            if (g_a[i] && g_b[i]) begin
                g_a[i] = 1'b0;
                g_b[i] = 1'b0;
                pend[i] = 1'b1;
                cnt[i] = ip_lat;
            end else if (pend[i]) begin
                if (cnt[i] <= 1) begin
                    pend[i] = 1'b0;
                    d = div_ref(i == 0, cap_a[i], cap_b[i]);
                    m_dout_tvalid[i] = 1'b1;
                    if (i == 0) m_dout_tdata_s = d;
                    else m_dout_tdata_u = d;
                end else begin
                    cnt[i] = cnt[i] - 1;
                end
            end else if (noise_en && i != int'(cur_op[1]) &&
                         $urandom_range(7) == 0) begin
                d = {$urandom, $urandom};
                m_dout_tvalid[i] = 1'b1;
                if (i == 0) m_dout_tdata_s = d;
                else m_dout_tdata_u = d;
            end
        end
        issue_cyc = busy ? issue_cyc + 1 : 0;
        if (script_en) begin
            s_dividend_tready = {2{issue_cyc >= dnd_at}};
            s_divisor_tready  = {2{issue_cyc >= dvs_at}};
        end else begin
            s_dividend_tready = 2'($urandom);
            s_divisor_tready  = 2'($urandom);
        end
        p_tv_a = s_dividend_tvalid;
        p_tv_b = s_divisor_tvalid;
        p_rd_a = s_dividend_tready;
        p_rd_b = s_divisor_tready;
    end

    // Monitor: scoreboard pops on each new done, protocol checks, driver checks
    logic [1:0] m_tv_a = 2'b00;
    logic [1:0] m_tv_b = 2'b00;
    logic [1:0] m_rd_a = 2'b00;
    logic [1:0] m_rd_b = 2'b00;
    bit         p_done = 1'b0;
    bit         p_busy = 1'b0;

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] e;
        logic [1:0]  wrong;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act !== c.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", c.name, c.act, c.exp);
            end
        end
        if (done && !p_done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got result %h want no done",
                         result);
            end else begin
                e = exp_q.pop_front();
                if (result !== e) begin
                    n_err++;
                    $display("FAIL result: got %h want %h", result, e);
                end
            end
        end
        if (busy && !p_busy) begin
            dnd_cnt = 0;
            dvs_cnt = 0;
        end
        if (|s_dividend_tvalid) dnd_cnt++;
        if (|s_divisor_tvalid) dvs_cnt++;
        if (|(s_dividend_tvalid | s_divisor_tvalid)) begin
            wrong = cur_op[1] ? 2'b01 : 2'b10;
            n_cmp++;
            if (((s_dividend_tvalid | s_divisor_tvalid) & wrong) != 2'b00) begin
                n_err++;
                $display("FAIL wrong_ip_tvalid: got %b/%b want bit %b low",
                         s_dividend_tvalid, s_divisor_tvalid, wrong);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (m_tv_a[i] && !m_rd_a[i]) begin
                n_cmp++;
                if (!s_dividend_tvalid[i]) begin
                    n_err++;
                    $display("FAIL dnd_hold[%0d]: got 0 want 1", i);
                end
            end
            if (m_tv_b[i] && !m_rd_b[i]) begin
                n_cmp++;
                if (!s_divisor_tvalid[i]) begin
                    n_err++;
                    $display("FAIL dvs_hold[%0d]: got 0 want 1", i);
                end
            end
        end
        m_tv_a = s_dividend_tvalid;
        m_tv_b = s_divisor_tvalid;
        m_rd_a = s_dividend_tready;
        m_rd_b = s_divisor_tready;
        p_done = done;
        p_busy = busy;
    end

    task automatic wait_idle(input string n);
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(n, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_wait();
        int t = 0;
        while ((|(s_dividend_tvalid | s_divisor_tvalid)) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("reach_wait", {31'h0, busy}, 32'h1);
    endtask

    task automatic check_reset_vals(input string n);
        check({n, "_busy"}, {31'h0, busy}, 32'h0);
        check({n, "_done"}, {31'h0, done}, 32'h0);
        check({n, "_result"}, result, 32'h0);
        check({n, "_tvalid"},
              {28'h0, s_dividend_tvalid, s_divisor_tvalid}, 32'h0);
    endtask

    // mode: 0 ack, 1 flush in ISSUE, 2 flush in WAIT, 3 flush in DONE, 4 reset in WAIT
    task automatic txn(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e,
                       input int mode);
        int d;
        wait_idle("idle_before");
        ip_lat = (mode == 2 || mode == 4) ? 8 : $urandom_range(1, 4);
        cur_op = op;
        req_op = op;
        src1 = a;
        src2 = b;
        req_valid = 1'b1;
        if (mode == 0 || mode == 3) exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom);
        src1 = $urandom;
        src2 = $urandom;
        case (mode)
            0, 3: begin
                wait_done();
                d = $urandom_range(2);
                repeat (d) @(negedge clk);
                check("result_hold", result, e);
                if (mode == 0) begin
                    res_ack = 1'b1;
                    req_valid = 1'b1;
                    @(negedge clk);
                    res_ack = 1'b0;
                    req_valid = 1'b0;
                    check("idle_gap", {31'h0, busy}, 32'h0);
                end else begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                    check("done_flush", {31'h0, done}, 32'h0);
                    check("done_flush_idle", {31'h0, busy}, 32'h0);
                end
                last_exp = e;
            end
            1, 2: begin
                if (mode == 2) wait_wait();
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                wait_idle("drain_idle");
                check("flush_keep", result, last_exp);
            end
            default: begin
                wait_wait();
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_reset_vals("wait_reset");
                repeat (12) @(negedge clk);
                check("late_done", {31'h0, done}, 32'h0);
                last_exp = 32'h0;
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          r;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        src1 = 32'h0;
        src2 = 32'h0;
        res_ack = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        script_en = 1'b1;
        dnd_at = 1;
        dvs_at = 1;
        txn(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        check("sdiv_dnd_cycles", dnd_cnt, 1);
        check("sdiv_dvs_cycles", dvs_cnt, 1);
        txn(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        txn(2'b11, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 0);
        txn(2'b10, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 0);

        dvs_at = 4;
        txn(2'b00, 32'd100, 32'd7, 32'd14, 0);
        check("stag_dnd_cycles", dnd_cnt, 1);
        check("stag_dvs_cycles", dvs_cnt, 4);
        txn(2'b01, 32'd100, 32'd7, 32'd0, 1);
        check("fiss_dnd_cycles", dnd_cnt, 1);
        check("fiss_dvs_cycles", dvs_cnt, 4);

        dvs_at = 1;
        txn(2'b10, 32'd50, 32'd5, 32'd10, 3);
        txn(2'b00, 32'd77, 32'd3, 32'd0, 2);
        txn(2'b10, 32'd9, 32'd2, 32'd4, 0);
        txn(2'b10, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0);
        txn(2'b11, 32'd1234, 32'd0, 32'd1234, 0);
        txn(2'b01, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 0);
        txn(2'b00, 32'd1000, 32'd10, 32'd0, 4);
        txn(2'b01, 32'd1000, 32'd7, 32'd6, 0);

        wait_idle("idle_flush_pre");
        req_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush", {31'h0, busy}, 32'h0);

        script_en = 1'b0;
        noise_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            op = 2'($urandom);
            a = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) - 32'd20
                                         : $urandom;
            case ($urandom_range(3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(9)) - 32'd4;
                default: b = $urandom;
            endcase
            r = $urandom_range(9);
            if (r <= 5) txn(op, a, b, expect_of(op, a, b), 0);
            else if (r == 6) txn(op, a, b, 32'h0, 1);
            else if (r == 7) txn(op, a, b, 32'h0, 2);
            else if (r == 8) txn(op, a, b, expect_of(op, a, b), 3);
            else txn(op, a, b, 32'h0, 4);
        end
        noise_en = 1'b0;

        wait_idle("idle_end");
        repeat (12) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'h0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
